// File: rtl/z80_ld_a_ind_nn_seq_pkg.sv
// Shared encodings for the LD A,(nn) bus-cycle sequencer and its M-cycle timer.
package z80_ld_a_ind_nn_seq_pkg;

    localparam logic [7:0] Z80_OP_LD_A_IND_NN = 8'h3A;
    localparam logic [3:0] LD_A_IND_NN_LEN    = 4'd3;

    typedef enum logic [2:0] {
        MC_IDLE   = 3'd0,
        MC_M1     = 3'd1,
        MC_M2     = 3'd2,
        MC_M3     = 3'd3,
        MC_M4     = 3'd4,
        MC_RETIRE = 3'd5,
        MC_UNSUP  = 3'd6
    } mstate_t;

    typedef enum logic [2:0] {
        T_T1 = 3'd0,
        T_T2 = 3'd1,
        T_TW = 3'd2,
        T_T3 = 3'd3,
        T_T4 = 3'd4
    } tstate_t;

    // Operand addresses wrap at 64K like the real address bus.
    function automatic logic [15:0] ip_offset(input logic [15:0] ip, input logic [1:0] off);
        return ip + {14'd0, off};
    endfunction

endpackage

// File: rtl/z80_mcycle_timer.sv
// T-state sequencer for one M-cycle: 4T opcode fetch or 3T memory read, with WAIT insertion.
module z80_mcycle_timer
    import z80_ld_a_ind_nn_seq_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    run,
    input  logic    is_m1,
    input  logic    bus_wait,
    output tstate_t t_next,
    output logic    last_t,
    output logic    capture
);

    tstate_t t_state_r;

    // Next T-state; idle timer parks on T1 so the next M-cycle starts cleanly.
    always_comb begin
        t_next = T_T1;
        if (run) begin
            case (t_state_r)
                T_T1:       t_next = T_T2;
                T_T2, T_TW: t_next = bus_wait ? T_TW : T_T3;
                T_T3:       t_next = is_m1 ? T_T4 : T_T1;
                T_T4:       t_next = T_T1;
                default:    t_next = T_T1;
            endcase
        end else begin
            t_next = T_T1;
        end
    end

    // Opcode fetch samples data when leaving T2/Tw; plain reads sample at the end of T3.
    always_comb begin
        last_t  = 1'b0;
        capture = 1'b0;
        if (run) begin
            last_t  = is_m1 ? (t_state_r == T_T4) : (t_state_r == T_T3);
            capture = is_m1 ? (((t_state_r == T_T2) || (t_state_r == T_TW)) && !bus_wait)
                            : (t_state_r == T_T3);
        end else begin
            last_t  = 1'b0;
            capture = 1'b0;
        end
    end

    // T-state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            t_state_r <= T_T1;
        end else begin
            t_state_r <= t_next;
        end
    end

endmodule

// File: rtl/z80_ld_a_ind_nn_seq.sv
// LD A,(nn) sequencer: M1 fetch, nn_lo/nn_hi operand reads, data read from nn, then A write and retirement.
module z80_ld_a_ind_nn_seq
    import z80_ld_a_ind_nn_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ip_in,
    input  logic [7:0]  a_in,
    input  logic        bus_wait,
    input  logic [7:0]  bus_data_in,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_m1,
    output logic        busy,
    output logic        a_we,
    output logic [7:0]  a_wdata,
    output logic [15:0] ip_out,
    output logic        unsupported,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [3:0]  z80fi_insn_len,
    output logic [15:0] z80fi_mem_raddr,
    output logic [7:0]  z80fi_mem_rdata,
    output logic [7:0]  z80fi_reg_a_in,
    output logic [15:0] z80fi_reg_ip_in
);

    mstate_t     state_r, state_s;
    tstate_t     t_next_s;
    logic        last_t_s, capture_s, run_s, is_m1_s, latch_s;
    logic [15:0] ip_r, ip_s;
    logic [7:0]  opcode_r, opcode_s, nn_lo_r, nn_lo_s, nn_hi_r, nn_hi_s, data_r, data_s;
    logic [15:0] addr_s;
    logic        rd_s, m1_s;

    assign run_s   = (state_r == MC_M1) || (state_r == MC_M2) ||
                     (state_r == MC_M3) || (state_r == MC_M4);
    assign is_m1_s = (state_r == MC_M1);
    assign latch_s = start && ((state_r == MC_IDLE) || (state_r == MC_RETIRE));

    z80_mcycle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (run_s),
        .is_m1    (is_m1_s),
        .bus_wait (bus_wait),
        .t_next   (t_next_s),
        .last_t   (last_t_s),
        .capture  (capture_s)
    );

    // M-cycle sequencing; RETIRE accepts a queued start for back-to-back issue.
    always_comb begin
        state_s = state_r;
        case (state_r)
            MC_IDLE:   state_s = latch_s ? MC_M1 : MC_IDLE;
            MC_M1: begin
                if (last_t_s) begin
                    state_s = (opcode_r == Z80_OP_LD_A_IND_NN) ? MC_M2 : MC_UNSUP;
                end else begin
                    state_s = MC_M1;
                end
            end
            MC_M2:     state_s = last_t_s ? MC_M3 : MC_M2;
            MC_M3:     state_s = last_t_s ? MC_M4 : MC_M3;
            MC_M4:     state_s = last_t_s ? MC_RETIRE : MC_M4;
            MC_RETIRE: state_s = latch_s ? MC_M1 : MC_IDLE;
            MC_UNSUP:  state_s = MC_IDLE;
            default:   state_s = MC_IDLE;
        endcase
    end

    // Byte latches; next values feed the output registers so the bus sees them in the same cycle.
    always_comb begin
        ip_s     = latch_s ? ip_in : ip_r;
        opcode_s = ((state_r == MC_M1) && capture_s) ? bus_data_in : opcode_r;
        nn_lo_s  = ((state_r == MC_M2) && capture_s) ? bus_data_in : nn_lo_r;
        nn_hi_s  = ((state_r == MC_M3) && capture_s) ? bus_data_in : nn_hi_r;
        data_s   = ((state_r == MC_M4) && capture_s) ? bus_data_in : data_r;
    end

    // Bus strobes and address decoded from the upcoming state so the pins come straight off flops.
    always_comb begin
        addr_s = 16'h0000;
        rd_s   = 1'b0;
        m1_s   = 1'b0;
        case (state_s)
            MC_M1: begin
                addr_s = ip_s;
                rd_s   = (t_next_s == T_T1) || (t_next_s == T_T2) || (t_next_s == T_TW);
                m1_s   = rd_s;
            end
            MC_M2: begin
                addr_s = ip_offset(ip_s, 2'd1);
                rd_s   = 1'b1;
            end
            MC_M3: begin
                addr_s = ip_offset(ip_s, 2'd2);
                rd_s   = 1'b1;
            end
            MC_M4: begin
                addr_s = {nn_hi_s, nn_lo_s};
                rd_s   = 1'b1;
            end
            default: begin
                addr_s = 16'h0000;
                rd_s   = 1'b0;
                m1_s   = 1'b0;
            end
        endcase
    end

    // State, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= MC_IDLE;
            ip_r            <= 16'h0000;
            opcode_r        <= 8'h00;
            nn_lo_r         <= 8'h00;
            nn_hi_r         <= 8'h00;
            data_r          <= 8'h00;
            bus_addr        <= 16'h0000;
            bus_rd          <= 1'b0;
            bus_m1          <= 1'b0;
            busy            <= 1'b0;
            a_we            <= 1'b0;
            a_wdata         <= 8'h00;
            ip_out          <= 16'h0000;
            unsupported     <= 1'b0;
            z80fi_valid     <= 1'b0;
            z80fi_insn      <= 32'h0000_0000;
            z80fi_insn_len  <= 4'd0;
            z80fi_mem_raddr <= 16'h0000;
            z80fi_mem_rdata <= 8'h00;
            z80fi_reg_a_in  <= 8'h00;
            z80fi_reg_ip_in <= 16'h0000;
        end else begin
            state_r     <= state_s;
            ip_r        <= ip_s;
            opcode_r    <= opcode_s;
            nn_lo_r     <= nn_lo_s;
            nn_hi_r     <= nn_hi_s;
            data_r      <= data_s;
            bus_addr    <= addr_s;
            bus_rd      <= rd_s;
            bus_m1      <= m1_s;
            busy        <= (state_s != MC_IDLE);
            a_we        <= (state_s == MC_RETIRE);
            z80fi_valid <= (state_s == MC_RETIRE);
            unsupported <= (state_s == MC_UNSUP);
            if (latch_s) begin
                z80fi_reg_a_in  <= a_in;
                z80fi_reg_ip_in <= ip_in;
            end
            // Retirement payload is frozen on entry to RETIRE and held until the next one.
            if (state_s == MC_RETIRE) begin
                a_wdata         <= data_s;
                ip_out          <= ip_r + 16'd3;
                z80fi_insn      <= {8'h00, nn_hi_r, nn_lo_r, opcode_r};
                z80fi_insn_len  <= LD_A_IND_NN_LEN;
                z80fi_mem_raddr <= {nn_hi_r, nn_lo_r};
                z80fi_mem_rdata <= data_s;
            end
        end
    end

endmodule
